// File: rtl/pow_fsmd_param_if.sv
// pow_fsmd_param_if: go/busy/done handshake, operands and result of the power unit.
interface pow_fsmd_param_if #(
  parameter int BASE_W = 8,
  parameter int EXP_W  = 8,
  parameter int RES_W  = 16
);
  logic              go_i;
  logic [BASE_W-1:0] a_i;
  logic [EXP_W-1:0]  n_i;
  logic [RES_W-1:0]  result_o;
  logic              ovf_o;
  logic              done_o;
  logic              busy_o;
  logic [2:0]        state_o;
  modport master (output go_i, a_i, n_i, input result_o, ovf_o, done_o, busy_o, state_o);
  modport slave  (input go_i, a_i, n_i, output result_o, ovf_o, done_o, busy_o, state_o);
endinterface

// File: rtl/pow_fsmd_param.sv
// pow_fsmd_param: a^n FSMD, repeated multiply (ALG=0) or LSB-first square-and-multiply (ALG=1).
module pow_fsmd_param #(
  parameter int BASE_W = 8,
  parameter int EXP_W  = 8,
  parameter int RES_W  = 16,
  parameter int ALG    = 0
) (
  input logic              clk,
  input logic              rst,
  pow_fsmd_param_if.slave  bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, CALC = 3'd1, FINISH = 3'd2} state_t;
  state_t             state_q;
  logic [RES_W-1:0]   acc_q, base_q, result_q;
  logic [EXP_W-1:0]   e_q;
  logic               acc_ovf_q, base_ovf_q, ovf_q, done_q;
  logic [2*RES_W-1:0] acc_d, base_d;
  assign acc_d  = {{RES_W{1'b0}}, acc_q} * {{RES_W{1'b0}}, base_q};
  assign base_d = {{RES_W{1'b0}}, base_q} * {{RES_W{1'b0}}, base_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      base_q     <= '0;
      result_q   <= '0;
      e_q        <= '0;
      acc_ovf_q  <= 1'b0;
      base_ovf_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.go_i) begin
          base_q     <= RES_W'(bus.a_i);
          e_q        <= bus.n_i;
          acc_q      <= RES_W'(1);
          acc_ovf_q  <= 1'b0;
          base_ovf_q <= 1'b0;
          state_q    <= CALC;
        end
        CALC: if (e_q == '0) state_q <= FINISH;
        else if (ALG == 0) begin
          acc_q     <= acc_d[RES_W-1:0];
          acc_ovf_q <= acc_ovf_q | (|acc_d[2*RES_W-1:RES_W]);
          e_q       <= e_q - EXP_W'(1);
        end else begin
          // an overflowed base only taints acc when it is actually multiplied in
          if (e_q[0]) begin
            acc_q     <= acc_d[RES_W-1:0];
            acc_ovf_q <= acc_ovf_q | (|acc_d[2*RES_W-1:RES_W]) | base_ovf_q;
          end
          base_q     <= base_d[RES_W-1:0];
          base_ovf_q <= base_ovf_q | (|base_d[2*RES_W-1:RES_W]);
          e_q        <= e_q >> 1;
        end
        FINISH: begin
          result_q <= acc_q;
          ovf_q    <= acc_ovf_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.result_o = result_q;
  assign bus.ovf_o    = ovf_q;
  assign bus.done_o   = done_q;
  assign bus.busy_o   = state_q != IDLE;
  assign bus.state_o  = state_q;
endmodule
